adc_arbiter: RTL and testbench

ADC_ARBITER -- requirements
Module: adc_arbiter

---
 rtl/adc_arbiter.sv | 110 +++++++++++
 tb/tb_adc_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/adc_arbiter.sv
// Round-robin arbiter that lets two requesters share one SPI ADC reader.
// A four-state FSM launches a conversion, waits for completion or timeout, then acks.
module adc_arbiter #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic [1:0]  ack,
  output logic [11:0] data_o,
  output logic        chan_o,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

  state_t      state, state_d;
  logic [1:0]  gnt_d, ack_d;
  logic [11:0] data_d;
  logic        chan_d, start_d, busy_d, terr_d;
  logic        last, last_d;
  logic [15:0] cnt, cnt_d;
  logic        pick;

  // On a tie the requester that was not served last wins.
  assign pick = (req == 2'b11) ? ~last : req[1];

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    ack_d   = 2'b00;
    data_d  = data_o;
    chan_d  = chan_o;
    start_d = 1'b0;
    terr_d  = timeout_err;
    last_d  = last;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_d   = pick ? 2'b10 : 2'b01;
          chan_d  = pick;
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion in the timeout cycle still delivers its data.
        if (adc_done) begin
          data_d  = adc_data;
          ack_d   = gnt;
          state_d = DONE;
        end else if (cnt == CNT_MAX) begin
          terr_d  = 1'b1;
          ack_d   = gnt;
          state_d = DONE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      DONE: begin
        last_d  = chan_o;
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= 2'b00;
      ack         <= 2'b00;
      data_o      <= '0;
      chan_o      <= 1'b0;
      adc_start   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      last        <= 1'b1;
      cnt         <= '0;
    end else begin
      state       <= state_d;
      gnt         <= gnt_d;
      ack         <= ack_d;
      data_o      <= data_d;
      chan_o      <= chan_d;
      adc_start   <= start_d;
      busy        <= busy_d;
      timeout_err <= terr_d;
      last        <= last_d;
      cnt         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_adc_arbiter.sv
// Scoreboard bench for adc_arbiter: expectations are queued when a request is
// driven and compared when the matching ack appears.
module tb_adc_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  gnt, ack;
  logic [11:0] data_o;
  logic        chan_o, adc_start, busy, timeout_err;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = 12'h000;

  typedef struct {
    logic [1:0]  gnt;
    logic [11:0] data;
    logic        terr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  logic        model_last = 1'b1;
  logic [11:0] model_data = 12'h000;
  logic        model_terr = 1'b0;

  adc_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .ack(ack), .data_o(data_o),
    .chan_o(chan_o), .adc_start(adc_start), .adc_done(adc_done),
    .adc_data(adc_data), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (adc_start) start_cnt <= start_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (!rst) check("gnt_onehot", 32'($countones(gnt) <= 1), 1);

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; adc_done = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1; model_data = 12'h000; model_terr = 1'b0;
    check("rst_gnt", gnt, 0);
    check("rst_ack", ack, 0);
    check("rst_start", adc_start, 0);
    check("rst_chan", chan_o, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data_o, 0);
    check("rst_terr", timeout_err, 0);
  endtask

  // dly: WAIT cycle (1-based) carrying adc_done; 0 means never (timeout).
  task automatic run_txn(input logic [1:0] r, input int dly, input logic [11:0] d, input bit drop);
    exp_t e;
    exp_t got_e;
    logic idx;
    int   lat, starts0;
    bit   seen, got;
    idx   = (r == 2'b11) ? ~model_last : r[1];
    e.gnt = idx ? 2'b10 : 2'b01;
    if (dly >= 1 && dly <= 8) model_data = d;
    else model_terr = 1'b1;
    e.data = model_data;
    e.terr = model_terr;
    model_last = idx;
    sb.push_back(e);

    req = r;
    starts0 = start_cnt;
    seen = 0; lat = 0;
    while (!seen && lat < 6) begin
      @(negedge clk);
      lat++;
      seen = adc_start;
    end
    check("start_latency", lat, 1);
    check("start_gnt", gnt, e.gnt);
    check("start_chan", chan_o, idx);
    check("start_busy", busy, 1);
    if (drop) req = 2'b00;

    got = 0;
    adc_data = d;
    for (int i = 1; i <= 24 && !got; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        got = 1;
        if (sb.size() == 0) check("sb_empty", 1, 0);
        else begin
          got_e = sb.pop_front();
          check("ack_val", ack, got_e.gnt);
          check("done_gnt", gnt, got_e.gnt);
          check("done_data", data_o, got_e.data);
          check("done_terr", timeout_err, got_e.terr);
          check("done_busy", busy, 1);
        end
      end else begin
        adc_done = (i == dly);
      end
    end
    adc_done = 1'b0;
    if (!got) check("ack_timeout", 0, 1);
    check("start_pulses", start_cnt - starts0, 1);
    @(negedge clk);
    check("ack_width", ack, 0);
    check("gnt_release", gnt, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single requester, done on the 5th WAIT cycle.
    run_txn(2'b01, 5, 12'hABC, 0);
    req = 2'b00;

    // Both requesting from reset: 01, 10, 01.
    do_reset();
    run_txn(2'b11, 2, 12'h111, 0);
    run_txn(2'b11, 3, 12'h222, 0);
    run_txn(2'b11, 1, 12'h333, 0);
    req = 2'b00;
    @(negedge clk);

    // Done arrives in the last allowed WAIT cycle: data wins, no error.
    run_txn(2'b01, 8, 12'h123, 0);
    req = 2'b00;
    // No done at all: timeout, data unchanged, sticky error.
    run_txn(2'b10, 0, 12'hEEE, 0);
    req = 2'b00;
    run_txn(2'b01, 3, 12'h456, 0);
    req = 2'b00;

    // Request dropped after grant still completes.
    run_txn(2'b10, 4, 12'h5A5, 1);
    // Stray done in IDLE is ignored.
    adc_done = 1'b1; adc_data = 12'hFFF;
    @(negedge clk);
    adc_done = 1'b0;
    check("stray_data", data_o, model_data);
    check("stray_busy", busy, 0);
    check("stray_ack", ack, 0);

    // Reset during WAIT, then a late done.
    req = 2'b01;
    begin
      bit seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
        @(negedge clk);
        seen = adc_start;
      end
      check("abort_start_seen", seen, 1);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1; model_data = 12'h000; model_terr = 1'b0;
    adc_done = 1'b1; adc_data = 12'h777;
    @(negedge clk);
    adc_done = 1'b0;
    check("abort_terr", timeout_err, 0);
    check("abort_chan", chan_o, 0);
    check("abort_start", adc_start, 0);
    for (int i = 0; i < 4; i++) begin
      check("abort_ack", ack, 0);
      check("abort_data", data_o, 0);
      check("abort_busy", busy, 0);
      check("abort_gnt", gnt, 0);
      @(negedge clk);
    end
    // Pointer was reset, so player 0 wins the next tie.
    run_txn(2'b11, 2, 12'h9C3, 0);
    req = 2'b00;
    @(negedge clk);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
